// File: rtl/float_add_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the shared dual adder.
// The slave modport is the arbiter's view; master is the surrounding logic.
interface float_add_arbiter_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_DEPTH = 16
);
    localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a1;
    logic [DATA_W-1:0] req0_b1;
    logic [DATA_W-1:0] req0_a2;
    logic [DATA_W-1:0] req0_b2;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a1;
    logic [DATA_W-1:0] req1_b1;
    logic [DATA_W-1:0] req1_a2;
    logic [DATA_W-1:0] req1_b2;

    logic              add_ready;
    logic              add_valid;
    logic [DATA_W-1:0] add_din1_A;
    logic [DATA_W-1:0] add_din1_B;
    logic [DATA_W-1:0] add_din2_A;
    logic [DATA_W-1:0] add_din2_B;
    logic              add_done;
    logic [DATA_W-1:0] add_dout1;
    logic [DATA_W-1:0] add_dout2;

    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_dout1;
    logic [DATA_W-1:0] rsp0_dout2;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_dout1;
    logic [DATA_W-1:0] rsp1_dout2;

    logic [CntW-1:0]   inflight;
    logic              err_orphan;

    modport slave (
        input  req0_valid, req0_a1, req0_b1, req0_a2, req0_b2,
        input  req1_valid, req1_a1, req1_b1, req1_a2, req1_b2,
        output req0_ready, req1_ready,
        input  add_ready, add_done, add_dout1, add_dout2,
        output add_valid, add_din1_A, add_din1_B, add_din2_A, add_din2_B,
        output rsp0_valid, rsp0_dout1, rsp0_dout2,
        output rsp1_valid, rsp1_dout1, rsp1_dout2,
        output inflight, err_orphan
    );

    modport master (
        output req0_valid, req0_a1, req0_b1, req0_a2, req0_b2,
        output req1_valid, req1_a1, req1_b1, req1_a2, req1_b2,
        input  req0_ready, req1_ready,
        output add_ready, add_done, add_dout1, add_dout2,
        input  add_valid, add_din1_A, add_din1_B, add_din2_A, add_din2_B,
        input  rsp0_valid, rsp0_dout1, rsp0_dout2,
        input  rsp1_valid, rsp1_dout1, rsp1_dout2,
        input  inflight, err_orphan
    );
endinterface

// File: rtl/float_add_arbiter.sv
// Round-robin share of one dual float adder between two requesters. A 1-bit tag FIFO
// remembers who issued each in-flight operation so results are steered back in order.
module float_add_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned TAG_DEPTH = 16
) (
    input logic                clk,
    input logic                rst,
    float_add_arbiter_if.slave bus
);
    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [TAG_DEPTH-1:0] tag_mem_q, tag_mem_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;
    logic                 prio_q, prio_d;
    logic                 err_orphan_q, err_orphan_d;
    logic                 rsp0_valid_q, rsp0_valid_d;
    logic                 rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0]    rsp0_dout1_q, rsp0_dout1_d;
    logic [DATA_W-1:0]    rsp0_dout2_q, rsp0_dout2_d;
    logic [DATA_W-1:0]    rsp1_dout1_q, rsp1_dout1_d;
    logic [DATA_W-1:0]    rsp1_dout2_q, rsp1_dout2_d;

    logic tag_full, tag_empty;
    logic elig0, elig1, gnt0, gnt1;
    logic push, pop, head_tag;

    // Full blocks grants outright, even when a pop frees a slot this cycle.
    always_comb begin
        tag_full  = (count_q == CntW'(TAG_DEPTH));
        tag_empty = (count_q == '0);
        elig0     = bus.req0_valid & bus.add_ready & ~tag_full;
        elig1     = bus.req1_valid & bus.add_ready & ~tag_full;
        gnt0      = elig0 & (~elig1 | ~prio_q);
        gnt1      = elig1 & (~elig0 | prio_q);
        push      = gnt0 | gnt1;
        pop       = bus.add_done & ~tag_empty;
        head_tag  = tag_mem_q[rd_ptr_q];
    end

    always_comb begin
        bus.add_din1_A = '0;
        bus.add_din1_B = '0;
        bus.add_din2_A = '0;
        bus.add_din2_B = '0;
        if (gnt0) begin
            bus.add_din1_A = bus.req0_a1;
            bus.add_din1_B = bus.req0_b1;
            bus.add_din2_A = bus.req0_a2;
            bus.add_din2_B = bus.req0_b2;
        end else if (gnt1) begin
            bus.add_din1_A = bus.req1_a1;
            bus.add_din1_B = bus.req1_b1;
            bus.add_din2_A = bus.req1_a2;
            bus.add_din2_B = bus.req1_b2;
        end
    end

    always_comb begin
        tag_mem_d    = tag_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        prio_d       = prio_q;
        err_orphan_d = err_orphan_q;
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        rsp0_dout1_d = rsp0_dout1_q;
        rsp0_dout2_d = rsp0_dout2_q;
        rsp1_dout1_d = rsp1_dout1_q;
        rsp1_dout2_d = rsp1_dout2_q;

        if (push) begin
            tag_mem_d[wr_ptr_q] = gnt1;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
            prio_d              = gnt0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (head_tag) begin
                rsp1_valid_d = 1'b1;
                rsp1_dout1_d = bus.add_dout1;
                rsp1_dout2_d = bus.add_dout2;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_dout1_d = bus.add_dout1;
                rsp0_dout2_d = bus.add_dout2;
            end
        end

        if (bus.add_done && tag_empty) begin
            err_orphan_d = 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_mem_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            prio_q       <= 1'b0;
            err_orphan_q <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_dout1_q <= '0;
            rsp0_dout2_q <= '0;
            rsp1_dout1_q <= '0;
            rsp1_dout2_q <= '0;
        end else begin
            tag_mem_q    <= tag_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            prio_q       <= prio_d;
            err_orphan_q <= err_orphan_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_dout1_q <= rsp0_dout1_d;
            rsp0_dout2_q <= rsp0_dout2_d;
            rsp1_dout1_q <= rsp1_dout1_d;
            rsp1_dout2_q <= rsp1_dout2_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.add_valid  = push;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_dout1 = rsp0_dout1_q;
    assign bus.rsp0_dout2 = rsp0_dout2_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_dout1 = rsp1_dout1_q;
    assign bus.rsp1_dout2 = rsp1_dout2_q;
    assign bus.inflight   = count_q;
    assign bus.err_orphan = err_orphan_q;
endmodule

// File: doc/float_add_arbiter.md
# float_add_arbiter

Shares one `float_add_dual` instance between two requesters, for example two RNN gate units, using round-robin arbitration. It records the owner of every in-flight operation in a tag FIFO. Each result pair is steered back to the requester that issued it, one cycle after the adder signals done. It sits between the gate-level sequencers and the shared adder; the adder's ready, valid and done handshake passes through unchanged.

## Interface
- `DATA_W`, default 32: operand/result width (IEEE-754 single).
- `TAG_DEPTH`, default 16: maximum operations in flight; power of two, ≥2.
- `clk` in 1: single clock, all logic rising-edge.
- `rst` in 1: reset, synchronous, active-high.
- `reqN_valid` in 1 (N=0,1): requester N presents an operand set.
- `reqN_ready` out 1: requester N's operand set is accepted this cycle.
- `reqN_a1`, `reqN_b1`, `reqN_a2`, `reqN_b2` in DATA_W: lane-1 and lane-2 operands.
- `add_ready` in 1: shared adder can accept an operand set (`float_add_dual.ready`).
- `add_valid` out 1: operand set issued to the adder.
- `add_din1_A`, `add_din1_B`, `add_din2_A`, `add_din2_B` out DATA_W: muxed operands.
- `add_done` in 1: adder result valid (`float_add_dual.done`).
- `add_dout1`, `add_dout2` in DATA_W: adder results.
- `rspN_valid` out 1: one-cycle result strobe to requester N.
- `rspN_dout1`, `rspN_dout2` out DATA_W: registered result pair.
- `inflight` out $clog2(TAG_DEPTH)+1: count of issued operations without a result yet.
- `err_orphan` out 1: sticky; asserts when `add_done` arrives with no tag outstanding.

## Operation
- **Eligibility:** requester N is eligible when `reqN_valid & add_ready & !tag_full`.
- **Grant** (combinational):
  - One eligible requester: it is granted.
  - Both eligible: the requester selected by the 1-bit priority pointer `prio` is granted.
  - `reqN_ready` equals grant N; at most one is high in any cycle.
- **Issue:**
  - `add_valid` = OR of the grants.
  - `add_din*` = operands of the granted requester; all zeros when nothing is granted.
  - A transfer occurs when `reqN_valid & reqN_ready`.
- **Pointer:** after a transfer by N, `prio` ← !N. The pointer holds when there is no transfer.
- **Tag FIFO:**
  - Depth TAG_DEPTH, 1-bit entries. The requester ID is pushed on every transfer.
  - `tag_full` is asserted when the count equals TAG_DEPTH. While full, no grant is given, even if a pop occurs in the same cycle.
  - Read/write pointers wrap modulo TAG_DEPTH.
- **Return:**
  - On `add_done` with the FIFO non-empty, the head tag is popped.
  - Next cycle: `rsp<tag>_valid`=1 and `rsp<tag>_dout1/2` ← `add_dout1/2`.
  - The other requester's `rsp*_valid` stays 0; its data registers hold their old values.
  - The adder returns results in issue order and has no backpressure, so responses cannot be refused.
- **Orphan done:** `add_done` with the FIFO empty sets `err_orphan`; no pop, no response. Only `rst` clears `err_orphan`.
- **Simultaneous push and pop:** the count is unchanged and both pointers advance.
- **`inflight`:** equals the FIFO count.

## Timing
- **Reset values:**
  - `reqN_ready`=0, `add_valid`=0, `add_din*`=0.
  - `rspN_valid`=0, `rspN_dout*`=0.
  - `inflight`=0, `err_orphan`=0, `prio`=0 (requester 0 favoured).
  - FIFO emptied.
- **Reset mid-operation:** every in-flight tag is discarded. Any `add_done` arriving after reset is an orphan. The team resets the adder together with this block.
- **Issue path:** combinational, 0 cycles from `reqN_valid` to `add_valid`. There is no operand register.
- **Result return:** exactly 1 cycle from `add_done` to `rspN_valid`.
- **Throughput:** one issue per cycle and one return per cycle, concurrently.
- **Requester obligation:** `reqN_valid` and its operands stay stable until `reqN_ready`.

## Test plan
- **Single requester.** After reset, `req0_valid`=1 with a1=0x3F800000, b1=0x40000000, a2=0x40400000, b2=0x40800000, and `add_ready`=1 → same cycle: `req0_ready`=1, `add_valid`=1, operands passed through. On `add_done` with dout1=0x40400000, dout2=0x40E00000 → next cycle `rsp0_valid`=1 with those values, `rsp1_valid`=0, `inflight` returns to 0.
- **Both requesters held valid for 6 cycles, `add_ready`=1.** Grants go 0,1,0,1,0,1. Returning 6 done pulses produces `rsp` strobes in the order 0,1,0,1,0,1.
- **Backpressure.** `add_ready`=0 for 3 cycles with both requesters valid → no `reqN_ready`, `add_valid`=0, `prio` unchanged. The first grant after `add_ready` rises goes to requester 0.
- **Full FIFO (TAG_DEPTH=4).** Issue 4 operations with no done → `inflight`=4 and `reqN_ready`=0. Apply `add_done` and a new request in the same cycle → no grant that cycle; grant the following cycle, `inflight` stays at 4. Then drain four results and confirm the pointers wrap correctly.
- **Orphan.** `add_done` pulse right after reset → `err_orphan`=1 on the next cycle, no `rsp*_valid`. `err_orphan` stays 1 until `rst`.
- **Reset mid-operation.** Issue 3 operations, then assert `rst` → all outputs return to reset values and `inflight`=0. A subsequent late `add_done` sets `err_orphan`.
